// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// The ALU control decoder imports the same op encodings.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with a final sign fix-up and a one-cycle done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  md_state_e          state;
  logic [5:0]         cnt;
  logic [1:0]         op_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_mag = (op[0] && b[WIDTH-1]) ? -b : b;

  // Multiply keeps the multiplier in acc's low half and the partial product in
  // its high half; divide keeps the partial remainder high and the quotient low.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand & {WIDTH{acc[0]}}};
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, operand};
  assign rem_diff = rem_sh[WIDTH-1:0] - operand;

  always_comb begin
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (op_q[1]) begin
      if (div_ge)
        acc_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Signs are latched as zero for unsigned ops, so no op check is needed here.
  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    quot   = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi = op_q[1] ? rem  : prod[2*WIDTH-1:WIDTH];
    fix_lo = op_q[1] ? quot : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      operand <= '0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            dbz  <= 1'b0;
            if (op[1] && b == '0) begin
              hi    <= a;
              lo    <= '1;
              dbz   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              op_q    <= op;
              sign_a  <= op[0] & a[WIDTH-1];
              sign_b  <= op[0] & b[WIDTH-1];
              operand <= op[1] ? b_mag : a_mag;
              acc     <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              cnt     <= '0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          if (cnt == LAST_ITER) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, busy window,
// result hold, divide-by-zero, start re-pulse and reset abort.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dbz;

  int          tests;
  int          failures;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; pulses start for the current cycle, returns one cycle later.
  task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a_i,
                               input logic [31:0] b_i);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [1:0] op_i,
                       input logic [31:0] a_i, input logic [31:0] b_i,
                       input int exp_lat, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input logic exp_dbz,
                       input int repulse_at);
    int   lat;
    logic busy_ok;
    logic hold_ok;
    logic seen;
    lat     = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    seen    = 1'b0;
    applyStimulus(op_i, a_i, b_i);
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end else if (hi !== prev_hi || lo !== prev_lo) begin
        hold_ok = 1'b0;
      end
      if (!seen && k == repulse_at) begin
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd7;
        b     = 32'd9;
      end
      if (k == repulse_at + 1) start = 1'b0;
    end
    start = 1'b0;
    checkOutput({name, " latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, " busy"}, {63'd0, busy_ok}, 64'd1);
    checkOutput({name, " hold"}, {63'd0, hold_ok}, 64'd1);
    checkOutput({name, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    checkOutput({name, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    checkOutput({name, " dbz"}, {63'd0, dbz}, {63'd0, exp_dbz});
    prev_hi = exp_hi;
    prev_lo = exp_lo;
    @(negedge clk);
    checkOutput({name, " done pulse width"}, {63'd0, done}, 64'd0);
    checkOutput({name, " busy after"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic any_done;
    tests    = 0;
    failures = 0;
    prev_hi  = '0;
    prev_lo  = '0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = OP_MULTU;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset hi", {32'd0, hi}, 64'd0);
    checkOutput("reset lo", {32'd0, lo}, 64'd0);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset done", {63'd0, done}, 64'd0);
    checkOutput("reset dbz", {63'd0, dbz}, 64'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start with reset busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    runOp("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    runOp("mult -3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 34,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
    runOp("mult min^2", OP_MULT, 32'h8000_0000, 32'h8000_0000, 34,
          32'h4000_0000, 32'h0000_0000, 1'b0, 0);
    runOp("divu 100/7", OP_DIVU, 32'd100, 32'd7, 34,
          32'd2, 32'd14, 1'b0, 0);
    runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    runOp("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 34,
          32'd1, 32'hFFFF_FFFD, 1'b0, 0);
    runOp("divu 5/0", OP_DIVU, 32'd5, 32'd0, 1,
          32'd5, 32'hFFFF_FFFF, 1'b1, 0);
    runOp("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34,
          32'd0, 32'h8000_0000, 1'b0, 0);
    runOp("multu repulse", OP_MULTU, 32'd2, 32'd3, 34,
          32'd0, 32'd6, 1'b0, 5);

    applyStimulus(OP_MULTU, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", {63'd0, busy}, 64'd0);
    checkOutput("abort hi", {32'd0, hi}, 64'd0);
    checkOutput("abort lo", {32'd0, lo}, 64'd0);
    any_done = done;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) any_done = 1'b1;
    end
    checkOutput("abort no done", {63'd0, any_done}, 64'd0);
    prev_hi = '0;
    prev_lo = '0;

    runOp("multu after abort", OP_MULTU, 32'd12345, 32'd1000, 34,
          32'd0, 32'd12345000, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the 32-bit processor's execute stage, sitting directly upstream of the HI and LO 32-bit enable registers. It accepts MULT/MULTU/DIV/DIVU with a one-cycle start pulse and computes by radix-2 shift-add or restoring division. It then presents the 64-bit result as hi/lo together with a single-cycle `done` pulse, which drives the D_En of both HI and LO registers.

## Interface
- `WIDTH`, 32, operand width; `hi`/`lo` are each `WIDTH` bits; latency scales with `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock; sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WIDTH  multiplicand / dividend.
- `b`  in  WIDTH  multiplier / divisor.
- `hi`  out  WIDTH  product[63:32] or remainder.
- `lo`  out  WIDTH  product[31:0] or quotient.
- `busy`  out  1  operation in flight; `start` is ignored while high.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid in this cycle (HI/LO register enable).
- `dbz`  out  1  divide-by-zero flag; valid with `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE:**
  - If `start` is high, latch `op`, `|a|` and `|b|` (magnitudes only for signed ops), and the two operand sign bits.
  - A divide with `b`==0 goes to DONE. Every other op goes to CALC with the counter at 0.
- **CALC:** one iteration per cycle on magnitudes, using a 64-bit accumulator.
  - Multiply: add-and-shift.
  - Divide: restoring divide with a shift-subtract per cycle.
  - Exit to FIX after iteration `WIDTH-1`; the counter is 6 bits.
- **FIX:** apply signs for signed ops.
  - Product is negated (64-bit two's complement) when the operand signs differ.
  - Quotient is negated when the signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Then go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- Divide-by-zero: `lo`=all-ones, `hi`=`a` unmodified, `dbz`=1. `dbz` clears on the next accepted `start`.
- DIV 0x8000_0000 / 0xFFFF_FFFF: `lo`=0x8000_0000, `hi`=0, `dbz`=0. No trap.
- Unsigned ops ignore sign bits. All arithmetic is modulo 2^64 on the accumulator.
- `hi`/`lo` hold their last result until the next DONE; they never change outside DONE.
- **Reset (synchronous):** state=IDLE and counter=0; `hi`, `lo`, `busy`, `done` and `dbz` are all 0.
- Reset mid-operation aborts the operation. No `done` is produced for it.

## Timing
- Take `start` accepted in cycle N.
- **Normal op:**
  - CALC occupies N+1..N+WIDTH.
  - FIX occupies N+WIDTH+1.
  - DONE falls in N+WIDTH+2, i.e. N+34 for 32 bits.
- **Divide by zero:** DONE in N+1.
- `busy` is high from N+1 through the DONE cycle inclusive, and low in the next cycle.
- A new `start` is accepted in the cycle after DONE, which is back-to-back capable.
- `start` held high during `busy` has no effect and is not queued.
- `start` coincident with `reset`: reset wins.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings `OP_MULTU`/`OP_MULT`/`OP_DIVU`/`OP_DIV`;
  - the state enum;
  - the default width constant `MD_WIDTH`=32.
- The processor's ALU control decoder imports the same op constants.
- Single module with no sub-module. The FSM, counter and shared 64-bit accumulator/shifter live inline, roughly 200–300 lines.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF, start at N -> `done` only in N+34, `hi`=0xFFFF_FFFE, `lo`=0x0000_0001, `busy` high N+1..N+34.
- MULT −3 × 5 -> `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFF1. MULT 0x8000_0000 × 0x8000_0000 -> `hi`=0x4000_0000, `lo`=0.
- DIVU 100 / 7 -> `lo`=14, `hi`=2. DIV −7 / 2 -> `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF. DIV 7 / −2 -> `lo`=0xFFFF_FFFD, `hi`=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> `lo`=0x8000_0000, `hi`=0, `dbz`=0. DIVU 5 / 0 -> `done` in N+1, `lo`=0xFFFF_FFFF, `hi`=5, `dbz`=1.
- MULTU 2×3 started at N, `start` re-pulsed at N+5 with different operands -> single `done` at N+34 with `lo`=6. New `start` at N+35 is accepted.
- `reset` asserted in N+10 during CALC -> from N+11 `busy`=0, `hi`=`lo`=0, no `done` pulse ever appears; next `start` completes normally.
